dlsc_demosaic_mosaic: RTL and testbench
=======================================

DLSC_DEMOSAIC_MOSAIC -- requirements
Module: dlsc_demosaic_mosaic

Interface
REQ-001 SHALL have parameter DATA, default 8, giving bits per color component.
REQ-002 SHALL have parameter XB, default 12, giving the column counter width.
REQ-003 SHALL have parameter YB, default 12, giving the row counter width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 SHALL have port cfg_width, input, XB bits, giving pixels per row minus 1.
REQ-007 SHALL have port cfg_height, input, YB bits, giving rows per frame minus 1.
REQ-008 SHALL have port cfg_bayer, input, 2 bits, selecting the pattern: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
REQ-009 SHALL have port in_ready, output, 1 bit, indicating an RGB input beat can be accepted.
REQ-010 SHALL have port in_valid, input, 1 bit, indicating an RGB input beat is present.
REQ-011 SHALL have ports in_red, in_green and in_blue, each an input of DATA bits, carrying the RGB pixel.
REQ-012 SHALL have port out_ready, input, 1 bit, the downstream accept.
REQ-013 SHALL have port out_valid, output, 1 bit, indicating a Bayer output beat is present.
REQ-014 SHALL have port out_data, output, DATA bits, carrying the mosaiced sample.
REQ-015 SHALL have port out_last, output, 1 bit, marking the last pixel of a row.
REQ-016 SHALL have port out_frame, output, 1 bit, marking the last pixel of a frame.

Function
REQ-017 SHALL transfer an input beat when in_valid and in_ready are both high on a rising edge, and an output beat when out_valid and out_ready are both high.
REQ-018 SHALL keep column counter x (XB bits) and row counter y (YB bits), both starting at 0.
REQ-019 SHALL advance x on each accepted input beat; when x equals the latched width it SHALL wrap x to 0 and advance y.
REQ-020 SHALL wrap y to 0 when y equals the latched height and x wraps, which ends the frame.
REQ-021 SHALL latch cfg_width, cfg_height and cfg_bayer into shadow registers only when x=0 and y=0 and no accepted beat is mid-frame, so that config changes mid-frame take effect at the next frame.
REQ-022 SHALL compute phase bits px = x[0] xor bayer[0] and py = y[0] xor bayer[1], using the latched bayer value.
REQ-023 SHALL select red for (px,py)=(0,0), blue for (1,1), and green for (1,0) and (0,1).
REQ-024 SHALL present the selected component on out_data with out_valid one cycle after the input beat is accepted; latency is exactly 1 cycle when out_ready is high.
REQ-025 SHALL drive out_last high when the source x equals the latched width, and out_frame high when out_last is high and y equals the latched height.
REQ-026 SHALL use a 2-entry output skid buffer so that in_ready depends only on registered state, never combinationally on out_ready.
REQ-027 SHALL hold in_ready high iff the skid buffer holds fewer than 2 entries.
REQ-028 SHALL, on a simultaneous push and pop, keep the entry count unchanged and preserve order.
REQ-029 SHALL hold out_data, out_last and out_frame stable while out_valid is high and out_ready is low.
REQ-030 SHALL handle cfg_width=0 with every pixel having out_last=1 and y advancing each beat.
REQ-031 SHALL handle cfg_width=0 together with cfg_height=0 with every beat having both out_last and out_frame high.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear x, y, the skid entry count, out_valid, out_last and out_frame to 0.
REQ-033 SHALL hold in_ready at 0 while rst_n is low and drive it to 1 on the first cycle after deassertion.
REQ-034 SHALL reset the shadow configuration registers to 0 (RGGB, width 1, height 1) until they are first latched.
REQ-035 SHALL, when reset asserts mid-frame, discard any partial frame; the next accepted beat is pixel (0,0).
REQ-036 SHALL leave out_data unreset.

Structure
REQ-037 SHALL place the Bayer pattern encodings (RGGB=0, GRBG=1, GBRG=2, BGGR=3) in the shared demosaic package, so that the demosaic cores and this block share them.
REQ-038 SHALL implement the skid buffer as the single sub-module dlsc_demosaic_skid, parameterized by payload width DATA+2.

Verification
REQ-039 SHALL verify RGGB at cfg_width=3, cfg_height=1 with R=x, G=0x80, B=0xF0 and out_ready always high: output is 00,80,02,80 / 80,F0,80,F0 with out_last on beats 4 and 8 and out_frame on beat 8.
REQ-040 SHALL verify BGGR on the same frame: row 0 is F0,80,F0,80 and row 1 is 80,01,80,03.
REQ-041 SHALL verify backpressure with out_ready held low for 5 cycles: in_ready falls after 2 accepts, no beat is lost or duplicated, and out_data is held stable.
REQ-042 SHALL verify that changing cfg_bayer from 0 to 3 mid-frame leaves the current frame RGGB, with the next frame starting BGGR.
REQ-043 SHALL verify rst_n pulsed low after 3 beats: out_valid clears immediately, and the next frame's first beat is red at (0,0).
REQ-044 SHALL verify cfg_width=0 and cfg_height=0: every beat has out_last=1 and out_frame=1 and carries the red component.

Source files
------------

// File: rtl/dlsc_demosaic_pkg.sv
// Shared demosaic definitions: Bayer pattern encodings and the per-site
// colour-component selector used by the demosaic cores and the mosaic block.
package dlsc_demosaic_pkg;

    typedef enum logic [1:0] {
        BAYER_RGGB = 2'd0,
        BAYER_GRBG = 2'd1,
        BAYER_GBRG = 2'd2,
        BAYER_BGGR = 2'd3
    } bayer_e;

    typedef enum logic [1:0] {
        COMP_RED   = 2'd0,
        COMP_GREEN = 2'd1,
        COMP_BLUE  = 2'd2
    } comp_e;

    // Phase bits are the site coordinates already folded with the pattern.
    function automatic comp_e bayer_comp(input logic px, input logic py);
        comp_e c;
        case ({py, px})
            2'b00:   c = COMP_RED;
            2'b11:   c = COMP_BLUE;
            default: c = COMP_GREEN;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dlsc_demosaic_mosaic_if.sv
// RGB-in / Bayer-out stream bundle for the mosaic block.
interface dlsc_demosaic_mosaic_if #(parameter int DATA = 8);
    logic            in_valid;
    logic            in_ready;
    logic [DATA-1:0] in_red;
    logic [DATA-1:0] in_green;
    logic [DATA-1:0] in_blue;
    logic            out_valid;
    logic            out_ready;
    logic [DATA-1:0] out_data;
    logic            out_last;
    logic            out_frame;

    modport master (output in_valid, in_red, in_green, in_blue, out_ready,
                    input  in_ready, out_valid, out_data, out_last, out_frame);
    modport slave  (input  in_valid, in_red, in_green, in_blue, out_ready,
                    output in_ready, out_valid, out_data, out_last, out_frame);
endinterface

// File: rtl/dlsc_demosaic_skid.sv
// Two-entry output skid buffer; in_ready comes only from registered state.
// The low CTRL payload bits are reset, the remaining data bits are not.
module dlsc_demosaic_skid #(
    parameter int WIDTH = 10,
    parameter int CTRL  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             in_ready,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    logic [1:0]       cnt_q, cnt_d;
    logic             rdy_q;
    logic [WIDTH-1:0] e0_d, e1_d;
    logic [CTRL-1:0]  e0_ctl_q, e1_ctl_q;
    logic [WIDTH-1:CTRL] e0_dat_q, e1_dat_q;
    logic             push_s, pop_s;

    assign in_ready  = rdy_q && (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = {e0_dat_q, e0_ctl_q};

    // Entry 0 is always the head; entry 1 only fills while the head is stalled.
    always_comb begin
        push_s = in_valid && in_ready;
        pop_s  = out_valid && out_ready;
        cnt_d  = cnt_q;
        e0_d   = {e0_dat_q, e0_ctl_q};
        e1_d   = {e1_dat_q, e1_ctl_q};
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    e0_d = in_data;
                end else begin
                    e1_d = in_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = {e1_dat_q, e1_ctl_q};
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_data;
                end else begin
                    e0_d = {e1_dat_q, e1_ctl_q};
                    e1_d = in_data;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Occupancy, ready and control flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
            e0_ctl_q <= {CTRL{1'b0}};
            e1_ctl_q <= {CTRL{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
            e0_ctl_q <= e0_d[CTRL-1:0];
            e1_ctl_q <= e1_d[CTRL-1:0];
        end
    end

    // Payload data, intentionally unreset.
    always_ff @(posedge clk) begin
        e0_dat_q <= e0_d[WIDTH-1:CTRL];
        e1_dat_q <= e1_d[WIDTH-1:CTRL];
    end

endmodule

// File: rtl/dlsc_demosaic_mosaic.sv
// RGB to Bayer mosaic: picks one component per pixel from the frame position
// and the pattern latched at the start of each frame.
module dlsc_demosaic_mosaic
    import dlsc_demosaic_pkg::*;
#(
    parameter int DATA = 8,
    parameter int XB   = 12,
    parameter int YB   = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XB-1:0]   cfg_width,
    input  logic [YB-1:0]   cfg_height,
    input  logic [1:0]      cfg_bayer,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [DATA-1:0] in_red,
    input  logic [DATA-1:0] in_green,
    input  logic [DATA-1:0] in_blue,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [DATA-1:0] out_data,
    output logic            out_last,
    output logic            out_frame
);
    logic [XB-1:0]   x_q, x_d, wid_q, wid_d, eff_w_s;
    logic [YB-1:0]   y_q, y_d, hgt_q, hgt_d, eff_h_s;
    logic [1:0]      bay_q, bay_d, eff_b_s;
    logic            at_start_s, accept_s, last_s, frame_s, px_s, py_s;
    logic            skid_ready_s;
    logic [DATA-1:0] sel_s;
    logic [DATA+1:0] out_pl_s;

    assign in_ready = skid_ready_s;

    // At the frame origin the live config applies and is captured; after
    // that the shadow copy governs the rest of the frame.
    always_comb begin
        at_start_s = (x_q == {XB{1'b0}}) && (y_q == {YB{1'b0}});
        if (at_start_s) begin
            eff_w_s = cfg_width;
            eff_h_s = cfg_height;
            eff_b_s = cfg_bayer;
        end else begin
            eff_w_s = wid_q;
            eff_h_s = hgt_q;
            eff_b_s = bay_q;
        end
        wid_d    = eff_w_s;
        hgt_d    = eff_h_s;
        bay_d    = eff_b_s;
        accept_s = in_valid && skid_ready_s;
        px_s     = x_q[0] ^ eff_b_s[0];
        py_s     = y_q[0] ^ eff_b_s[1];
        case (bayer_comp(px_s, py_s))
            COMP_RED:  sel_s = in_red;
            COMP_BLUE: sel_s = in_blue;
            default:   sel_s = in_green;
        endcase
        last_s  = (x_q == eff_w_s);
        frame_s = last_s && (y_q == eff_h_s);
        x_d     = x_q;
        y_d     = y_q;
        if (accept_s) begin
            if (last_s) begin
                x_d = {XB{1'b0}};
                y_d = frame_s ? {YB{1'b0}} : (y_q + {{(YB-1){1'b0}}, 1'b1});
            end else begin
                x_d = x_q + {{(XB-1){1'b0}}, 1'b1};
            end
        end else begin
            x_d = x_q;
        end
    end

    // Position counters and shadow configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= {XB{1'b0}};
            y_q   <= {YB{1'b0}};
            wid_q <= {XB{1'b0}};
            hgt_q <= {YB{1'b0}};
            bay_q <= 2'd0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            wid_q <= wid_d;
            hgt_q <= hgt_d;
            bay_q <= bay_d;
        end
    end

    dlsc_demosaic_skid #(
        .WIDTH (DATA + 2),
        .CTRL  (2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (skid_ready_s),
        .in_valid  (in_valid),
        .in_data   ({sel_s, last_s, frame_s}),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_pl_s)
    );

    assign out_data  = out_pl_s[DATA+1:2];
    assign out_last  = out_pl_s[1];
    assign out_frame = out_pl_s[0];

endmodule

// File: tb/tb_dlsc_demosaic_mosaic.sv
// Bench for dlsc_demosaic_mosaic: directed table vectors, corner sequences
// and randomized traffic scored against a position/pattern lookup model.
module tb_dlsc_demosaic_mosaic;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cfg_width, cfg_height;
    logic [1:0]  cfg_bayer;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dlsc_demosaic_mosaic_if #(.DATA(8)) bus ();

    dlsc_demosaic_mosaic #(.DATA(8), .XB(12), .YB(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_bayer  (cfg_bayer),
        .in_ready   (bus.in_ready),
        .in_valid   (bus.in_valid),
        .in_red     (bus.in_red),
        .in_green   (bus.in_green),
        .in_blue    (bus.in_blue),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .out_last   (bus.out_last),
        .out_frame  (bus.out_frame)
    );

    // ---------------- reference model ----------------
    typedef struct packed {logic [7:0] d; logic l; logic f;} beat_t;
    // colour per pattern, indexed by (y%2)*2 + x%2 : 0 red, 1 green, 2 blue
    int    pat [4][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};
    beat_t expq[$];
    int    n_pix = 0, m_w = 0, m_h = 0, m_b = 0;
    logic  stall = 1'b0;
    beat_t hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            n_pix = 0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_stable", {bus.out_valid, bus.out_data, bus.out_last, bus.out_frame},
                    {1'b1, hold.d, hold.l, hold.f});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (expq.size() == 0) begin
                    chk("spurious_beat", 32'd1, 32'd0);
                end else begin
                    beat_t e;
                    e = expq.pop_front();
                    chk("model_beat", {bus.out_data, bus.out_last, bus.out_frame}, {e.d, e.l, e.f});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                int x, y, c, total;
                beat_t e;
                if (n_pix == 0) begin
                    m_w = int'(cfg_width);
                    m_h = int'(cfg_height);
                    m_b = int'(cfg_bayer);
                end
                total = (m_w + 1) * (m_h + 1);
                x = n_pix % (m_w + 1);
                y = n_pix / (m_w + 1);
                c = pat[m_b][(y % 2) * 2 + (x % 2)];
                e.d = (c == 0) ? bus.in_red : (c == 2) ? bus.in_blue : bus.in_green;
                e.l = (x == m_w);
                e.f = (n_pix == total - 1);
                expq.push_back(e);
                n_pix = (n_pix + 1) % total;
            end
            stall  = bus.out_valid && !bus.out_ready;
            hold.d = bus.out_data;
            hold.l = bus.out_last;
            hold.f = bus.out_frame;
        end
    end

    // ---------------- helpers ----------------
    task automatic send_beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bit ok = 1'b0;
        bus.in_red = r; bus.in_green = g; bus.in_blue = b; bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (expq.size() == 0 && !bus.out_valid) break;
        end
        chk("drain_empty", expq.size(), 32'd0);
    endtask

    typedef struct {
        logic [1:0] bayer;
        logic [7:0] r, g, b;
        logic [7:0] ed;
        logic       el, ef;
    } vec_t;
    vec_t       tbl[16];
    logic [7:0] exp_tab[16] = '{8'h00, 8'h80, 8'h02, 8'h80, 8'h80, 8'hF0, 8'h80, 8'hF0,
                                8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80, 8'h01, 8'h80, 8'h03};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bus.in_valid = 1'b0; bus.in_red = 8'h00; bus.in_green = 8'h00; bus.in_blue = 8'h00;
        bus.out_ready = 1'b1;
        cfg_width = 12'd3; cfg_height = 12'd1; cfg_bayer = 2'd0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 32'd0);
        chk("rst_out_valid", bus.out_valid, 32'd0);
        chk("rst_last_frame", {bus.out_last, bus.out_frame}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_rst", bus.in_ready, 32'd1);

        // directed frames: RGGB then BGGR, 4x2, R = column
        for (int i = 0; i < 16; i++) begin
            tbl[i].bayer = (i < 8) ? 2'd0 : 2'd3;
            tbl[i].r     = 8'(i % 4);
            tbl[i].g     = 8'h80;
            tbl[i].b     = 8'hF0;
            tbl[i].ed    = exp_tab[i];
            tbl[i].el    = ((i % 4) == 3);
            tbl[i].ef    = ((i % 8) == 7);
        end
        for (int i = 0; i < 16; i++) begin
            cfg_bayer = tbl[i].bayer;
            bus.in_red = tbl[i].r; bus.in_green = tbl[i].g; bus.in_blue = tbl[i].b;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            chk("table_beat", {bus.out_valid, bus.out_data, bus.out_last, bus.out_frame},
                {1'b1, tbl[i].ed, tbl[i].el, tbl[i].ef});
        end
        bus.in_valid = 1'b0;
        drain();

        // backpressure: out_ready low for 5 cycles
        cfg_bayer = 2'd0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_red = 8'($urandom); bus.in_green = 8'($urandom); bus.in_blue = 8'($urandom);
            @(negedge clk);
            if (bus.in_ready) acc++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("bp_accepts", acc, 32'd2);
        chk("bp_in_ready_low", bus.in_ready, 32'd0);
        chk("bp_out_valid", bus.out_valid, 32'd1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom));
        drain();

        // bayer change mid-frame takes effect next frame
        cfg_bayer = 2'd0;
        for (int i = 0; i < 3; i++) send_beat(8'h10 + 8'(i), 8'h20, 8'h30);
        cfg_bayer = 2'd3;
        for (int i = 0; i < 5; i++) send_beat(8'h10 + 8'(i), 8'h20, 8'h30);
        send_beat(8'h11, 8'h22, 8'h33);
        chk("next_frame_bggr", bus.out_data, 32'h33);
        for (int i = 0; i < 7; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom));
        drain();

        // reset pulsed after 3 beats
        cfg_bayer = 2'd0;
        for (int i = 0; i < 3; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom));
        bus.out_ready = 1'b0;
        send_beat(8'h44, 8'h55, 8'h66);
        rst_n = 1'b0;
        #1;
        chk("rst_clears_valid", bus.out_valid, 32'd0);
        chk("rst_clears_ready", bus.in_ready, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send_beat(8'hAA, 8'hBB, 8'hCC);
        chk("post_rst_red", {bus.out_data, bus.out_last}, {8'hAA, 1'b0});
        for (int i = 0; i < 7; i++) send_beat(8'($urandom), 8'($urandom), 8'($urandom));
        drain();

        // single-pixel frames
        cfg_width = 12'd0; cfg_height = 12'd0; cfg_bayer = 2'd0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            send_beat(r, ~r, r ^ 8'h5A);
            chk("w0h0_beat", {bus.out_data, bus.out_last, bus.out_frame}, {r, 1'b1, 1'b1});
        end
        drain();

        // randomized traffic with random config changes
        cfg_width = 12'd2; cfg_height = 12'd2;
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.out_ready = ($urandom_range(2) != 0);
            bus.in_red = 8'($urandom); bus.in_green = 8'($urandom); bus.in_blue = 8'($urandom);
            if ($urandom_range(40) == 0) begin
                cfg_width  = 12'($urandom_range(5));
                cfg_height = 12'($urandom_range(3));
                cfg_bayer  = 2'($urandom_range(3));
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
